load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store per request from the
//  pipeline, drives MemRead/MemWrite/address/writeData to the data memory, and returns
//  load data.
//  - Byte and halfword stores are done as read-modify-write, since the memory is word-wide.
//  - Load results are sign- or zero-extended to 32 bits.
//  - Sits between the EX/MEM pipeline stage and the data memory; the memory reads
//    combinationally and writes on the posedge.
// PARAMETERS
//  ADDR_W  32  byte-address width of req_addr / mem_addr
//  DATA_W  32  data width; fixed at 32 (lane logic assumes 4 bytes)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       pipeline presents a request
//  req_ready    out  1       LSU can accept (high only in IDLE)
//  req_write    in   1       1 = store, 0 = load
//  req_size     in   2       lsu_pkg::size_e: SZ_B=0, SZ_H=1, SZ_W=2 (3 treated as SZ_W)
//  req_unsigned in   1       load zero-extends when 1, sign-extends when 0
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   DATA_W  store data, right-justified (low bits used for B/H)
//  rsp_valid    out  1       one-cycle pulse: request complete
//  rsp_rdata    out  DATA_W  extended load data; 0 for stores; held until next rsp_valid
//  rsp_err      out  1       misaligned-access flag, valid with rsp_valid (see CONFIGURATION)
//  MemRead      out  1       memory read enable
//  MemWrite     out  1       memory write enable
//  address      out  ADDR_W  memory byte address, always word-aligned ([1:0]=0)
//  writeData    out  DATA_W  full merged word to write
//  readData     in   DATA_W  memory read data, combinational from address when MemRead=1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE.
//    Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, MemRead=0, MemWrite=0,
//    address=0, writeData=0.
//    Any in-flight op is abandoned; no partial write is issued after reset deasserts.
//  - Handshake: request accepted on the posedge where req_valid && req_ready.
//    - Fields are captured into registers; later changes on req_* are ignored.
//    - No rsp backpressure; exactly one rsp_valid per accepted request.
//  - FSM (lsu_pkg::state_e):
//    - IDLE      -> READ (load) | WRITE (word store) | RMW_RD (B/H store)
//    - READ      MemRead=1; readData captured at posedge -> RESP
//    - WRITE     MemWrite=1, writeData=req_wdata -> RESP
//    - RMW_RD    MemRead=1; capture old word -> RMW_WR
//    - RMW_WR    MemWrite=1, writeData=old word with the addressed lane(s) replaced -> RESP
//    - RESP      rsp_valid=1, req_ready=0 -> IDLE
//  - Latency from accept edge to rsp_valid cycle: load 2, word store 2, B/H store 3.
//    Back-to-back throughput is one request per 3 (or 4) cycles.
//  - MemRead/MemWrite/address/writeData decode from registered state and captured fields.
//    - No combinational path from req_* to memory ports.
//    - MemRead and MemWrite are never both 1.
//  - Lanes:
//    - Byte lane = addr[1:0]; half lane = addr[1], with addr[0] ignored.
//    - Word accesses ignore addr[1:0].
//    - address = {req_addr[ADDR_W-1:2], 2'b00}.
//  - Extension: byte uses bit 7 of the lane, half uses bit 15; no extension when
//    req_unsigned=1 or size=W.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - Half with addr[0]=1, or word with addr[1:0]!=0: IDLE -> RESP directly.
//    - No memory access: MemRead=MemWrite=0 throughout.
//    - rsp_err=1 and rsp_rdata=0 with rsp_valid; latency 1.
//  Not defined: rsp_err is tied 0 and misaligned low bits are ignored as described above.
// STRUCTURE
//  - lsu_pkg: size_e, state_e, lane-mask and extension helper functions.
//  - Sub-module lsu_align (combinational): lane extract+extend for loads,
//    lane merge for RMW stores.
//  - The top level holds the FSM and capture registers.
// TESTING
//  1. Word store 0xDEADBEEF @0x10, then load W @0x10 -> mem[4]=0xDEADBEEF; rsp_rdata=0xDEADBEEF
//     on cycle 2 after accept.
//  2. Byte store 0xAA @0x11 over 0xDEADBEEF -> RMW_RD then RMW_WR writes 0xDEADAAEF;
//     rsp_valid 3 cycles after accept.
//  3. Loads @0x13 of 0xDEADAAEF: signed B -> 0xFFFFFFDE, unsigned B -> 0x000000DE;
//     signed H @0x12 -> 0xFFFFDEAD.
//  4. rst_n low during RMW_WR -> MemWrite drops immediately, mem unchanged, req_ready=1
//     after release.
//  5. req_valid held high for 10 cycles with back-to-back loads -> each accepted only in
//     IDLE; one rsp_valid each; MemRead&&MemWrite never 1.
//  6. Word load @0x12: with LSU_MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0, no MemRead;
//     without it -> returns mem[4], rsp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and lane helpers for the load/store unit.
//   size_e   : access size (byte / half / word)
//   state_e  : load/store unit FSM states
//   lane_mask        : byte-enable mask of the addressed lane(s)
//   load_extend      : extract the addressed lane and sign/zero-extend it
//   store_merge      : replace the addressed lane(s) of an old word
//   misaligned       : half with addr[0]=1, or word with addr[1:0]!=0
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;

  // Halfword lane is chosen by off[1] only; off[0] is ignored for halves.
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e sz,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Store data is right-justified, so replicate it across every lane and let
  // the mask pick which lanes actually take the new bytes.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                              input size_e sz, input logic [1:0] off);
    logic [31:0] rep;
    logic [3:0]  m;
    logic [31:0] r;
    case (sz)
      SZ_B:    rep = {4{wdata[7:0]}};
      SZ_H:    rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    m = lane_mask(sz, off);
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = m[i] ? rep[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for the load/store unit.
//   rdata_i    in  32  word read from memory (load path)
//   old_i      in  32  previously read word (read-modify-write path)
//   wdata_i    in  32  right-justified store data
//   size_i     in  2   access size (size_e)
//   off_i      in  2   byte offset within the word
//   uns_i      in  1   zero-extend loads when 1
//   ld_data_o  out 32  extracted and extended load result
//   st_data_o  out 32  old word with the addressed lane(s) replaced
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  assign ld_data_o = load_extend(rdata_i, size_i, off_i, uns_i);
  assign st_data_o = store_merge(old_i, wdata_i, size_i, off_i);

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator side of the word-wide data-memory port. Accepts one load/store
// per request, performs byte/half stores as read-modify-write and returns
// sign/zero-extended load data.
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready request handshake (ready only in IDLE)
//   req_write       1 = store, 0 = load
//   req_size        0 = byte, 1 = half, 2/3 = word
//   req_unsigned    zero-extend load result
//   req_addr        byte address
//   req_wdata       right-justified store data
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       extended load data (0 for stores), held between responses
//   rsp_err         misaligned-access flag, qualified by rsp_valid
//   MemRead/MemWrite/address/writeData/readData  data-memory port
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses without touching memory (rsp_err=1); otherwise rsp_err is 0 and
// the misaligned low address bits are ignored.
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  state_e            state_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              accept;
  size_e             req_sz;
  state_e            op_state_d;

  // Captured request fields; not reset, they are only consumed after a
  // handshake has loaded them.
  logic              write_q;
  size_e             size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;

  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;

  assign accept = req_valid && (state_q == IDLE);

  // Size code 3 behaves as a word access.
  always_comb begin
    req_sz = (req_size == 2'd3) ? SZ_W : size_e'(req_size);
  end

  always_comb begin
    op_state_d = READ;
    if (req_write) begin
      op_state_d = (req_sz == SZ_W) ? WRITE : RMW_RD;
    end
  end

  // ---- Request capture / old-word capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      size_q  <= req_sz;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state_q == RMW_RD) begin
      old_q <= readData;
    end
  end

  lsu_align u_align (
    .rdata_i   (readData),
    .old_i     (old_q),
    .wdata_i   (wdata_q),
    .size_i    (size_q),
    .off_i     (addr_q[1:0]),
    .uns_i     (uns_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic rsp_err_q;
`endif

  // ---- FSM and response registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned(req_sz, req_addr[1:0])) begin
              state_q     <= RESP;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q   <= op_state_d;
              rsp_err_q <= 1'b0;
            end
`else
            state_q <= op_state_d;
`endif
          end
        end
        READ: begin
          rsp_rdata_q <= ld_data;
          state_q     <= RESP;
        end
        WRITE: begin
          rsp_rdata_q <= '0;
          state_q     <= RESP;
        end
        RMW_RD: begin
          state_q <= RMW_WR;
        end
        RMW_WR: begin
          rsp_rdata_q <= '0;
          state_q     <= RESP;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // ---- Memory port and response decode (registered state only) ----
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign MemRead   = (state_q == READ)  || (state_q == RMW_RD);
  assign MemWrite  = (state_q == WRITE) || (state_q == RMW_WR);
  assign address   = (MemRead || MemWrite) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;

  always_comb begin
    writeData = '0;
    if (state_q == WRITE) begin
      writeData = wdata_q;
    end else if (state_q == RMW_WR) begin
      writeData = st_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: directed scenarios followed by random loads/stores,
// compared against a byte-arithmetic memory model.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .writeData(writeData), .readData(readData)
  );

  // Data memory: combinational read, posedge write.
  assign readData = MemRead ? mem[address[7:2]] : 32'd0;
  always @(posedge clk) begin
    if (MemWrite) mem[address[7:2]] <= writeData;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: plain byte arithmetic ----
  function automatic int eff_size(input logic [1:0] sz);
    return (sz == 2'd3) ? 2 : int'(sz);
  endfunction

  function automatic int lane_shift(input int sz, input int off);
    if (sz == 0) return off * 8;
    if (sz == 1) return (off / 2) * 16;
    return 0;
  endfunction

  function automatic logic [31:0] size_mask(input int sz);
    if (sz == 0) return 32'h0000_00FF;
    if (sz == 1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz, input int off,
                                           input logic uns);
    logic [31:0] m;
    logic [31:0] v;
    int          top;
    m   = size_mask(sz);
    v   = (w >> lane_shift(sz, off)) & m;
    top = (sz == 0) ? 7 : 15;
    if (!uns && sz < 2 && v[top]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                            input int sz, input int off);
    logic [31:0] m;
    int          sh;
    sh = lane_shift(sz, off);
    m  = size_mask(sz) << sh;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  // Drives one request from a negedge and follows it to completion; returns
  // at the negedge after the response.
  task automatic do_op(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int nacc, output int bad, output logic pulse_after);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_write    = ~wr;
    req_size     = 2'($urandom);
    req_unsigned = ~uns;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    lat  = 99;
    nacc = 0;
    bad  = 0;
    rd   = 32'hxxxx_xxxx;
    er   = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (MemRead && MemWrite) bad++;
      if ((MemRead || MemWrite) && address[1:0] != 2'b00) bad++;
      if (MemRead || MemWrite) nacc++;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
    @(negedge clk);
    pulse_after = rsp_valid;
  endtask

  task automatic run_check(input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    int          s, off, e_lat, e_acc, lat, nacc, bad;
    logic        mis, er, pa;
    logic [31:0] e_rd, rd;
    s     = eff_size(sz);
    off   = int'(addr[1:0]);
    mis   = TRAP && ((s == 1 && addr[0]) || (s == 2 && addr[1:0] != 2'b00));
    if (mis) begin
      e_rd = 32'd0; e_lat = 1; e_acc = 0;
    end else if (!wr) begin
      e_rd = ref_load(ref_mem[addr[7:2]], s, off, uns); e_lat = 2; e_acc = 1;
    end else begin
      e_rd  = 32'd0;
      e_lat = (s == 2) ? 2 : 3;
      e_acc = (s == 2) ? 1 : 2;
      ref_mem[addr[7:2]] = ref_store(ref_mem[addr[7:2]], wd, s, off);
    end
    do_op(wr, sz, uns, addr, wd, rd, er, lat, nacc, bad, pa);
    chk({tag, ".lat"},   lat,  e_lat);
    chk({tag, ".rdata"}, rd,   e_rd);
    chk({tag, ".err"},   {31'd0, er}, {31'd0, mis});
    chk({tag, ".nacc"},  nacc, e_acc);
    chk({tag, ".port"},  bad,  0);
    chk({tag, ".pulse"}, {31'd0, pa}, 32'd0);
  endtask

  initial begin
    int          acc, rsp, bad, diffs;
    logic [31:0] e_w;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst.memrd",     {31'd0, MemRead}, 32'd0);
    chk("rst.memwr",     {31'd0, MemWrite}, 32'd0);
    chk("rst.address",   address, 32'd0);
    chk("rst.wdata",     writeData, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then word load
    run_check("t1.stw", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("t1.mem4", mem[4], 32'hDEAD_BEEF);
    run_check("t1.ldw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Byte store via read-modify-write
    run_check("t2.stb", 1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_56AA);
    chk("t2.mem4", mem[4], 32'hDEAD_AAEF);

    // Extension
    run_check("t3.lbs", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    run_check("t3.lbu", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    run_check("t3.lhs", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("t3.lhs.const", ref_load(32'hDEAD_AAEF, 1, 2, 1'b0), 32'hFFFF_DEAD);

    // Reset in the middle of RMW_WR abandons the write
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4.in_rmw_wr", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4.memwr_drop", {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid || MemWrite || MemRead || !req_ready) bad++;
    end
    chk("t4.quiet", bad, 0);
    chk("t4.mem4", mem[4], 32'hDEAD_AAEF);

    // req_valid held high across back-to-back loads
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    acc = 0; rsp = 0; bad = 0;
    e_w = ref_load(ref_mem[4], 2, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (req_ready) acc++;
      if (MemRead && MemWrite) bad++;
      if (rsp_valid) begin
        rsp++;
        if (rsp_rdata !== e_w) bad++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (MemRead && MemWrite) bad++;
      if (rsp_valid) begin
        rsp++;
        if (rsp_rdata !== e_w) bad++;
      end
      @(negedge clk);
    end
    chk("t5.accepts", acc, 4);
    chk("t5.rsps", rsp, 4);
    chk("t5.bad", bad, 0);

    // Misaligned word load
    run_check("t6.ldw_mis", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    if (TRAP) e_w = 32'd0;
    else      e_w = 32'hDEAD_AAEF;
    run_check("t6.ldw_mis2", 1'b0, 2'd3, 1'b0, 32'h12, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      run_check("rnd", 1'($urandom), 2'($urandom), 1'($urandom),
                32'($urandom_range(0, 63)), $urandom);
    end
    diffs = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i] !== ref_mem[i]) diffs++;
    end
    chk("memimage", diffs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
